// File: rtl/prover_beta_expand_early.sv
// Beta-table expander: each round doubles the populated part of the table by
// multiplying with the round challenge tau, using one bit-serial modular multiplier.
`ifndef F_NBITS
`define F_NBITS 8
`endif
`ifndef F_Q
`define F_Q 251
`endif

module prover_beta_expand_early #(
    parameter int nValBits = 3,
    parameter int nValues  = 1 << nValBits
) (
    input  logic                                clk,
    input  logic                                rstb,
    input  logic                                en,
    input  logic                                restart,
    input  logic [`F_NBITS-1:0]                 tau,
    output logic [nValues-1:0][`F_NBITS-1:0]    vals_out,
    output logic                                ready,
    output logic                                ready_pulse,
    output logic                                full
);

    localparam int FN = `F_NBITS;
    localparam int LW = $clog2(nValBits + 1);
    localparam int CW = (FN > 1) ? $clog2(FN) : 1;
    localparam logic [FN:0] Q = (FN + 1)'(`F_Q);

    if (nValues != (1 << nValBits) || nValBits < 1) begin : g_bad_params
        $error("prover_beta_expand_early: nValues must equal 1<<nValBits, nValBits >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  en_dly;
    logic                  ready_dly;
    logic [LW-1:0]         layer;
    logic [nValBits-1:0]   idx;
    logic [FN-1:0]         t;
    logic [FN-1:0]         acc;
    logic [CW-1:0]         bit_cnt;

    logic                  start;
    logic [FN-1:0]         operand;
    logic [FN:0]           dbl, dbl_red, sum, sum_red;
    logic [FN-1:0]         mul_step;
    logic [FN:0]           diff;
    logic [nValBits-1:0]   hi_idx;

    assign start       = en & ~en_dly;
    assign ready       = (state == IDLE) & ~start;
    assign ready_pulse = ready & ~ready_dly;

    // Interleaved add-and-double: both operands are < q, so one conditional
    // subtract after the double and one after the add keep the accumulator reduced.
    assign operand  = vals_out[idx];
    assign dbl      = {1'b0, acc} + {1'b0, acc};
    assign dbl_red  = (dbl >= Q) ? dbl - Q : dbl;
    assign sum      = dbl_red + {1'b0, operand};
    assign sum_red  = (sum >= Q) ? sum - Q : sum;
    assign mul_step = t[bit_cnt] ? sum_red[FN-1:0] : dbl_red[FN-1:0];

    // vals[i] - p mod q; adding q back on borrow keeps the result in [0, q).
    assign diff   = (operand >= acc) ? {1'b0, operand} - {1'b0, acc}
                                     : {1'b0, operand} + Q - {1'b0, acc};
    // idx < 2^layer, so OR-ing in bit 'layer' is the same as adding 2^layer.
    assign hi_idx = idx | (nValBits'(1) << layer);

    // NOTE: next-state logic assigns its default first so no path leaves
    // state_nxt unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start && (restart || !full)) state_nxt = MUL;
            MUL:     if (bit_cnt == '0) state_nxt = WRITE;
            WRITE:   state_nxt = (idx == '0) ? IDLE : MUL;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every register below, including the table, uses non-blocking
    // assignments so all updates in a cycle see the pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            en_dly    <= 1'b1;
            ready_dly <= 1'b1;
        end else begin
            state     <= state_nxt;
            en_dly    <= en;
            ready_dly <= ready;
        end
    end

    // NOTE: the table is a small flop array with a defined reset value
    // ([1,0,..]), so it is reset like any other register rather than as a RAM.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vals_out    <= '0;
            vals_out[0] <= FN'(1);
            layer       <= '0;
            full        <= 1'b0;
            idx         <= '0;
            t           <= '0;
            acc         <= '0;
            bit_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (restart || !full)) begin
                        t       <= tau;
                        acc     <= '0;
                        bit_cnt <= CW'(FN - 1);
                        if (restart) begin
                            vals_out    <= '0;
                            vals_out[0] <= FN'(1);
                            layer       <= '0;
                            full        <= 1'b0;
                            idx         <= '0;
                        end else begin
                            idx <= nValBits'((1 << layer) - 1);
                        end
                    end
                end
                MUL: begin
                    acc <= mul_step;
                    if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
                end
                WRITE: begin
                    vals_out[hi_idx] <= acc;
                    vals_out[idx]    <= diff[FN-1:0];
                    if (idx == '0) begin
                        layer <= layer + 1'b1;
                        full  <= ((32'(layer) + 1) == nValBits);
                    end else begin
                        idx     <= idx - 1'b1;
                        acc     <= '0;
                        bit_cnt <= CW'(FN - 1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
